// File: rtl/mul_bist_pkg.sv
// Shared types and widths for the multiplier self-test block and its
// sequential reference multiplier.
package mul_bist_pkg;

   localparam int unsigned OP_W       = 4;
   localparam int unsigned PROD_W     = 8;
   localparam int unsigned VEC_W      = 2 * OP_W;
   localparam int unsigned REF_CYCLES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_e;

endpackage

// File: rtl/mul_ref_seq.sv
// Golden 4x4 unsigned multiplier: one shift-add step per cycle. The first
// partial product is folded into the load, so the result and ref_done are
// ready on the 4th cycle after ref_start.
module mul_ref_seq
   import mul_bist_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ref_start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              ref_done,
   output logic [PROD_W-1:0] ref_prod
);

   localparam int unsigned CNT_W = $clog2(REF_CYCLES);

   logic [PROD_W-1:0] mcand_q, mcand_d;
   logic [OP_W-1:0]   mplier_q, mplier_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  step_q, step_d;
   logic              run_q, run_d;
   logic              done_q, done_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      step_d   = step_q;
      run_d    = run_q;
      done_d   = done_q;
      if (ref_start) begin
         mcand_d  = PROD_W'(a) << 1;
         mplier_d = b >> 1;
         acc_d    = b[0] ? PROD_W'(a) : '0;
         step_d   = CNT_W'(1);
         run_d    = 1'b1;
         done_d   = 1'b0;
      end else if (run_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         step_d   = step_q + CNT_W'(1);
         if (step_q == CNT_W'(REF_CYCLES - 1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         step_q   <= '0;
         run_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         step_q   <= step_d;
         run_q    <= run_d;
         done_q   <= done_d;
      end
   end

   assign ref_done = done_q;
   assign ref_prod = acc_q;

endmodule

// File: rtl/mul_bist.sv
// Exhaustive self-test of an external 4x4 multiplier: sweeps all 256 operand
// pairs, compares against a sequential reference and logs the first failure.
module mul_bist
   import mul_bist_pkg::*;
#(
   parameter int unsigned LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [OP_W-1:0]   op_a,
   output logic [OP_W-1:0]   op_b,
   input  logic [PROD_W-1:0] product,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [PROD_W-1:0] err_count,
   output logic [PROD_W-1:0] fail_vec,
   output logic [PROD_W-1:0] fail_prod
);

   localparam int unsigned WAIT_CYC = (LAT > REF_CYCLES) ? LAT : REF_CYCLES;
   localparam int unsigned WCNT_W   = $clog2(WAIT_CYC);

   state_e              state_q, state_d;
   logic [VEC_W-1:0]    vec_q, vec_d;
   logic [VEC_W-1:0]    op_q, op_d;
   logic [PROD_W-1:0]   err_q, err_d;
   logic [PROD_W-1:0]   fvec_q, fvec_d;
   logic [PROD_W-1:0]   fprod_q, fprod_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                ref_start;
   logic                ref_done;
   logic [PROD_W-1:0]   ref_prod;
   logic                mismatch;

   assign ref_start = (state_q == ST_DRIVE);
   assign mismatch  = (product != ref_prod);

   mul_ref_seq u_ref (
      .clk       (clk),
      .rst       (rst),
      .ref_start (ref_start),
      .a         (op_q[VEC_W-1:OP_W]),
      .b         (op_q[OP_W-1:0]),
      .ref_done  (ref_done),
      .ref_prod  (ref_prod)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
         ST_DRIVE:         state_d = ST_WAIT;
         ST_WAIT:          if (wcnt_q == '0 && ref_done) state_d = ST_CHECK;
         ST_CHECK:         state_d = (vec_q == '1) ? ST_DONE : ST_DRIVE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered status; operands load on entry to DRIVE so they
   // are stable for the whole DRIVE..CHECK window of a vector.
   always_comb begin
      vec_d   = vec_q;
      op_d    = op_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fprod_d = fprod_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               vec_d   = '0;
               err_d   = '0;
               fvec_d  = '0;
               fprod_d = '0;
            end
         end
         ST_DRIVE: wcnt_d = WCNT_W'(WAIT_CYC - 1);
         ST_WAIT:  if (wcnt_q != '0) wcnt_d = wcnt_q - WCNT_W'(1);
         ST_CHECK: begin
            if (mismatch) begin
               if (err_q != '1) err_d = err_q + PROD_W'(1);
               if (err_q == '0) begin
                  fvec_d  = op_q;
                  fprod_d = product;
               end
            end
            if (vec_q != '1) vec_d = vec_q + VEC_W'(1);
         end
         default: ;
      endcase
      if (state_d == ST_DRIVE) op_d = vec_d;
      busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (err_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q   <= '0;
         op_q    <= '0;
         err_q   <= '0;
         fvec_q  <= '0;
         fprod_q <= '0;
         wcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         vec_q   <= vec_d;
         op_q    <= op_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fprod_q <= fprod_d;
         wcnt_q  <= wcnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign op_a      = op_q[VEC_W-1:OP_W];
   assign op_b      = op_q[OP_W-1:0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fvec_q;
   assign fail_prod = fprod_q;

endmodule

// File: tb/tb_mul_bist.sv
// Bench for mul_bist: a combinational DUT model (good / bit0 stuck / all-ones)
// on a LAT=0 instance and a 6-stage pipelined good DUT on a LAT=6 instance.
module tb_mul_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start0, start6;
   logic [3:0] op_a0, op_b0, op_a6, op_b6;
   logic [7:0] product0, product6;
   logic       busy0, done0, pass0, busy6, done6, pass6;
   logic [7:0] err0, fv0, fp0, err6, fv6, fp6;
   int         mode;
   int         sel;

   mul_bist #(.LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .op_a(op_a0), .op_b(op_b0),
      .product(product0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_vec(fv0), .fail_prod(fp0)
   );

   mul_bist #(.LAT(6)) u_dut6 (
      .clk(clk), .rst(rst), .start(start6), .op_a(op_a6), .op_b(op_b6),
      .product(product6), .busy(busy6), .done(done6), .pass(pass6),
      .err_count(err6), .fail_vec(fv6), .fail_prod(fp6)
   );

   // Multiplier-under-test models
   always_comb begin
      case (mode)
         1:       product0 = (8'(op_a0) * 8'(op_b0)) & 8'hFE;
         2:       product0 = 8'hFF;
         default: product0 = 8'(op_a0) * 8'(op_b0);
      endcase
   end

   logic [7:0] pipe [6];
   always_ff @(posedge clk) begin
      pipe[0] <= 8'(op_a6) * 8'(op_b6);
      for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
   end
   assign product6 = pipe[5];

   logic       busy_s, done_s, pass_s;
   logic [7:0] err_s, fv_s, fp_s, ops_s;
   always_comb begin
      busy_s = (sel != 0) ? busy6 : busy0;
      done_s = (sel != 0) ? done6 : done0;
      pass_s = (sel != 0) ? pass6 : pass0;
      err_s  = (sel != 0) ? err6  : err0;
      fv_s   = (sel != 0) ? fv6   : fv0;
      fp_s   = (sel != 0) ? fp6   : fp0;
      ops_s  = (sel != 0) ? {op_a6, op_b6} : {op_a0, op_b0};
   end

   typedef struct {
      int sel;
      int mode;
      int err;
      int fvec;
      int fprod;
      int pass;
      int cycles;
   } sweep_t;

   sweep_t rows [4];
   sweep_t sb [$];
   int     nvec = 0;
   int     nerr = 0;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) start6 = v;
      else          start0 = v;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, int'(busy_s), 0);
      chk({tag, "_done"}, int'(done_s), 0);
      chk({tag, "_pass"}, int'(pass_s), 0);
      chk({tag, "_err"},  int'(err_s),  0);
      chk({tag, "_fvec"}, int'(fv_s),   0);
      chk({tag, "_fprod"}, int'(fp_s),  0);
      chk({tag, "_ops"},  int'(ops_s),  0);
   endtask

   // Launch a sweep; the expected outcome goes to the scoreboard at launch
   // and is popped when the DUT reports done.
   task automatic run_sweep(input sweep_t exp, input bit mid_start);
      sweep_t e;
      int     cyc;
      int     guard;
      sel  = exp.sel;
      mode = exp.mode;
      sb.push_back(exp);
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      chk("first_vec", int'(ops_s), 0);
      cyc   = 0;
      guard = 0;
      while (!done_s && guard < 5000) begin
         if (busy_s) cyc++;
         set_start(mid_start && cyc == 700);
         @(negedge clk);
         guard++;
      end
      set_start(1'b0);
      e = sb.pop_front();
      chk("done",      int'(done_s), 1);
      chk("busy_len",  cyc,          e.cycles);
      chk("pass",      int'(pass_s), e.pass);
      chk("err_count", int'(err_s),  e.err);
      chk("fail_vec",  int'(fv_s),   e.fvec);
      chk("fail_prod", int'(fp_s),   e.fprod);
      repeat (3) @(negedge clk);
      chk("done_hold", int'(done_s), 1);
      chk("busy_idle", int'(busy_s), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rows[0] = '{0, 1, 64,  'h11, 'h00, 0, 1536};
      rows[1] = '{0, 2, 255, 'h00, 'hFF, 0, 1536};
      rows[2] = '{0, 0, 0,   'h00, 'h00, 1, 1536};
      rows[3] = '{1, 0, 0,   'h00, 'h00, 1, 2048};

      rst = 1'b1; start0 = 1'b0; start6 = 1'b0; mode = 0; sel = 0;
      repeat (3) @(negedge clk);
      chk_zero("rst0");
      sel = 1;
      chk_zero("rst6");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_sweep(rows[i], 1'b0);

      // start pulsed mid-sweep must not disturb the running sweep
      run_sweep(rows[0], 1'b1);

      // Reset during WAIT of vec 100, together with start
      sel = 0; mode = 1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      guard = 0;
      while (int'(ops_s) != 'h64 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("reach_vec100", int'(ops_s), 'h64);
      @(negedge clk);
      chk("pre_rst_err",  int'(err_s), 24);
      chk("pre_rst_fvec", int'(fv_s),  'h11);
      rst = 1'b1; start0 = 1'b1;
      @(negedge clk);
      rst = 1'b0; start0 = 1'b0;
      chk_zero("mid_rst");
      @(negedge clk);
      chk("idle_after_rst", int'(busy_s), 0);

      run_sweep(rows[2], 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mul_bist.md
MUL_BIST -- requirements
Module: mul_bist

Interface
REQ-001 The block SHALL have parameter LAT, default 0: DUT product latency in clk edges after an operand change, legal range 0..7.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that launches a self-test sweep.
REQ-005 The block SHALL have port op_a, output, 4 bits: multiplicand driven to the array multiplier under test, registered.
REQ-006 The block SHALL have port op_b, output, 4 bits: multiplier driven to the DUT, registered.
REQ-007 The block SHALL have port product, input, 8 bits: the result returned by the DUT.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is running.
REQ-009 The block SHALL have port done, output, 1 bit: high from sweep completion until the next start or rst.
REQ-010 The block SHALL have port pass, output, 1 bit: high with done when err_count equals 0.
REQ-011 The block SHALL have port err_count, output, 8 bits: number of mismatching vectors, saturating at 255.
REQ-012 The block SHALL have port fail_vec, output, 8 bits: {op_a, op_b} of the first mismatch; 0 if there was none.
REQ-013 The block SHALL have port fail_prod, output, 8 bits: the DUT product captured at the first mismatch.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-015 IDLE or DONE, start=1 -> DRIVE, with vec=0, err_count=0, fail_vec=0, fail_prod=0 and done=0.
REQ-016 DRIVE, lasting 1 cycle, SHALL set {op_a,op_b}=vec, pulse ref_start to the reference multiplier, then -> WAIT.
REQ-017 WAIT SHALL last exactly max(LAT,4) cycles, i.e. until the reference result is done and the latency counter has expired, then -> CHECK.
REQ-018 op_a and op_b SHALL stay constant from DRIVE through CHECK of the same vector.
REQ-019 CHECK, lasting 1 cycle, SHALL compare product with the reference result.
REQ-020 On a mismatch, err_count SHALL increment, saturating at 255.
REQ-021 On a mismatch, fail_vec and fail_prod SHALL be captured only when err_count was 0 before the increment.
REQ-022 CHECK with vec=255 -> DONE; otherwise vec increments by 1 -> DRIVE.
REQ-023 Each vector SHALL take 2+max(LAT,4) cycles; a full sweep SHALL take 256*(2+max(LAT,4)) cycles from the DRIVE of vec 0.
REQ-024 busy SHALL be high in DRIVE, WAIT and CHECK; done SHALL be high only in DONE.
REQ-025 pass SHALL equal done AND (err_count==0).
REQ-026 start SHALL be ignored while busy is high.
REQ-027 start in DONE SHALL restart the sweep, clearing all results.
REQ-028 The reference SHALL be an unsigned 4x4 to 8-bit product, computed sequentially by shift-add, with no use of a multiply operator.

Reset
REQ-029 rst=1 SHALL force IDLE at the next edge, from any state including mid-sweep.
REQ-030 Under reset, op_a, op_b, vec, err_count, fail_vec and fail_prod SHALL be 0, and busy, done and pass SHALL be 0.
REQ-031 rst SHALL take priority over start in the same cycle.
REQ-032 rst SHALL abort any reference multiplication in progress.

Structure
REQ-033 A shared package mul_bist_pkg SHALL hold the FSM state enum, OP_W=4, PROD_W=8 and REF_CYCLES=4.
REQ-034 The block SHALL contain one sub-module, mul_ref_seq: a 4-cycle shift-add multiplier with ports clk, rst, ref_start, a, b, ref_done and ref_prod.
REQ-035 mul_ref_seq SHALL load a and b on ref_start, assert ref_done on the 4th cycle, and hold ref_prod until the next ref_start.

Verification
REQ-036 Correct combinational DUT, LAT=0: start -> busy for 1536 cycles, then done=1, pass=1, err_count=0, fail_vec=0.
REQ-037 DUT with product bit 0 stuck at 0 -> done=1, pass=0, err_count=64, fail_vec=0x11, fail_prod=0x00.
REQ-038 LAT=6 with a 6-stage pipelined correct DUT -> 2048-cycle sweep, pass=1.
REQ-039 rst asserted at vec=100 during WAIT -> next cycle IDLE, all outputs 0; a later start restarts from vec 0.
REQ-040 start pulsed during a sweep -> no effect on vec, err_count or sweep length.
REQ-041 DUT always returning 0xFF -> err_count saturates at 255, fail_vec=0x00, fail_prod=0xFF.
